// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared forwarding encodings, shadow-entry type and helpers
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic       wena;
    logic       is_load;
  } shadow_t;
  // $0 is never a real destination, so it can neither forward nor interlock
  function automatic logic writes_reg(shadow_t e, logic [4:0] a);
    return e.valid & e.wena & (e.waddr != REG_ZERO) & (e.waddr == a);
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_mux_sel.sv
// hazard_fwd_mux_sel: priority operand-source select (EX > MEM > WB > regfile)
module hazard_fwd_mux_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] addr_i,
  input  logic       used_i,
  input  shadow_t    ex_i,
  input  shadow_t    mem_i,
  input  shadow_t    wb_i,
  output logic [1:0] sel_o
);
  // a load in EX has no data yet; the interlock covers it, so fall through to MEM
  always_comb
    sel_o = (!used_i || addr_i == REG_ZERO)              ? FWD_REG :
            (writes_reg(ex_i, addr_i) && !ex_i.is_load)  ? FWD_EX  :
            writes_reg(mem_i, addr_i)                    ? FWD_MEM :
            writes_reg(wb_i, addr_i)                     ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / mul-div interlock and EX operand forwarding selects
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_id_valid,
  input  logic       in_flush,
  input  logic [4:0] in_id_rs_addr,
  input  logic [4:0] in_id_rt_addr,
  input  logic       in_id_rs_used,
  input  logic       in_id_rt_used,
  input  logic [4:0] in_id_rd_waddr,
  input  logic       in_id_rd_wena,
  input  logic       in_id_is_load,
  input  logic       in_id_is_muldiv,
  output logic       out_stall,
  output logic       out_hold_pc,
  output logic       out_hold_if_id,
  output logic [1:0] out_fwd_a_sel,
  output logic [1:0] out_fwd_b_sel,
  output logic       out_muldiv_busy
);
  shadow_t ex_q, ex_d, mem_q, wb_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_use, md_lock, issue;
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  always_comb begin
    load_use = ex_q.is_load & ((in_id_rs_used & writes_reg(ex_q, in_id_rs_addr)) |
                               (in_id_rt_used & writes_reg(ex_q, in_id_rt_addr)));
    md_lock   = in_id_is_muldiv & (cnt_q != '0);
    out_stall = in_id_valid & ~in_flush & (load_use | md_lock);
    issue     = in_id_valid & ~in_flush & ~out_stall;
    ex_d      = issue ? '{valid: 1'b1, waddr: in_id_rd_waddr, wena: in_id_rd_wena,
                          is_load: in_id_is_load} : '0;
    cnt_d     = (issue & in_id_is_muldiv) ? CNT_W'(MULDIV_CYCLES - 1) :
                (cnt_q != '0)             ? cnt_q - CNT_W'(1) : cnt_q;
  end
  assign out_hold_pc     = out_stall;
  assign out_hold_if_id  = out_stall;
  assign out_muldiv_busy = cnt_q != '0;
  hazard_fwd_mux_sel u_sel_a (
    .addr_i(in_id_rs_addr), .used_i(in_id_rs_used),
    .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(out_fwd_a_sel)
  );
  hazard_fwd_mux_sel u_sel_b (
    .addr_i(in_id_rt_addr), .used_i(in_id_rt_used),
    .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(out_fwd_b_sel)
  );
endmodule
